// File: rtl/rapcores_bus_arbiter_if.sv
// Bundles the M0 Wishbone, M1 debug and shared register-bus signals of rapcores_bus_arbiter.
// The arbiter connects through the slave modport; the surrounding masters and register file use master.
interface rapcores_bus_arbiter_if #(
  parameter int unsigned ADR_W = 32
);
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [ADR_W-1:0] wbs_adr_i;
  logic [31:0]      wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;

  logic             dbg_req_i;
  logic             dbg_we_i;
  logic [3:0]       dbg_sel_i;
  logic [ADR_W-1:0] dbg_adr_i;
  logic [31:0]      dbg_dat_i;
  logic             dbg_ack_o;
  logic [31:0]      dbg_dat_o;

  logic             reg_cyc_o;
  logic             reg_stb_o;
  logic             reg_we_o;
  logic [3:0]       reg_sel_o;
  logic [ADR_W-1:0] reg_adr_o;
  logic [31:0]      reg_dat_o;
  logic             reg_ack_i;
  logic [31:0]      reg_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  dbg_req_i, dbg_we_i, dbg_sel_i, dbg_adr_i, dbg_dat_i,
    output dbg_ack_o, dbg_dat_o,
    output reg_cyc_o, reg_stb_o, reg_we_o, reg_sel_o, reg_adr_o, reg_dat_o,
    input  reg_ack_i, reg_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output dbg_req_i, dbg_we_i, dbg_sel_i, dbg_adr_i, dbg_dat_i,
    input  dbg_ack_o, dbg_dat_o,
    input  reg_cyc_o, reg_stb_o, reg_we_o, reg_sel_o, reg_adr_o, reg_dat_o,
    output reg_ack_i, reg_dat_i
  );
endinterface

// File: rtl/rapcores_bus_arbiter.sv
// Round-robin arbiter sharing the RAPcores register bus between the SoC Wishbone port (M0)
// and the LA debug master (M1). Define RAPCORES_ARB_TIMEOUT_EN to terminate hung accesses.
module rapcores_bus_arbiter #(
  parameter int unsigned ADR_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  rapcores_bus_arbiter_if.slave bus,
  output logic                  err_o
);
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } req_t;

  state_t           state, state_n;
  req_t             req_q, req_n, m0_payload, m1_payload;
  logic             stb_q, stb_n;
  logic             grant_q, grant_n;   // 1 = M1 owns the current access
  logic             last_q, last_n;     // 1 = M1 was granted most recently
  logic             wbs_ack_q, wbs_ack_n, dbg_ack_q, dbg_ack_n;
  logic [DAT_W-1:0] wbs_dat_q, wbs_dat_n, dbg_dat_q, dbg_dat_n;
  logic             err_q, err_n;
  logic             m0_req, m1_req, pick_m1, hold;

`ifdef RAPCORES_ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W        = 8;
  localparam logic [CNT_W-1:0] TMO_LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DAT_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  assign cnt_inc = cnt_q + CNT_W'(1);
`endif

  assign m0_req     = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign m1_req     = bus.dbg_req_i;
  assign pick_m1    = m1_req & (~m0_req | ~last_q);
  assign hold       = grant_q ? bus.dbg_req_i : bus.wbs_cyc_i;
  assign m0_payload = {bus.wbs_we_i, bus.wbs_sel_i, bus.wbs_adr_i, bus.wbs_dat_i};
  assign m1_payload = {bus.dbg_we_i, bus.dbg_sel_i, bus.dbg_adr_i, bus.dbg_dat_i};

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      req_q     <= '0;
      stb_q     <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      wbs_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      wbs_dat_q <= '0;
      dbg_dat_q <= '0;
      err_q     <= 1'b0;
`ifdef RAPCORES_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      req_q     <= req_n;
      stb_q     <= stb_n;
      grant_q   <= grant_n;
      last_q    <= last_n;
      wbs_ack_q <= wbs_ack_n;
      dbg_ack_q <= dbg_ack_n;
      wbs_dat_q <= wbs_dat_n;
      dbg_dat_q <= dbg_dat_n;
      err_q     <= err_n;
`ifdef RAPCORES_ARB_TIMEOUT_EN
      cnt_q     <= cnt_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    req_n     = req_q;
    stb_n     = stb_q;
    grant_n   = grant_q;
    last_n    = last_q;
    wbs_ack_n = 1'b0;
    dbg_ack_n = 1'b0;
    wbs_dat_n = wbs_dat_q;
    dbg_dat_n = dbg_dat_q;
    err_n     = err_q;
`ifdef RAPCORES_ARB_TIMEOUT_EN
    cnt_n     = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (m0_req | m1_req) begin
          grant_n = pick_m1;
          last_n  = pick_m1;
          req_n   = pick_m1 ? m1_payload : m0_payload;
          stb_n   = 1'b1;
          state_n = BUSY;
`ifdef RAPCORES_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      BUSY: begin
        // A register-file ack always beats an abort or a timeout in the same cycle
        if (bus.reg_ack_i) begin
          stb_n   = 1'b0;
          state_n = DONE;
          if (grant_q) begin
            dbg_ack_n = 1'b1;
            dbg_dat_n = bus.reg_dat_i;
          end else begin
            wbs_ack_n = 1'b1;
            wbs_dat_n = bus.reg_dat_i;
          end
        end else if (!hold) begin
          stb_n   = 1'b0;
          state_n = IDLE;
`ifdef RAPCORES_ARB_TIMEOUT_EN
        end else if (cnt_inc == TMO_LIMIT) begin
          stb_n   = 1'b0;
          err_n   = 1'b1;
          state_n = DONE;
          if (grant_q) begin
            dbg_ack_n = 1'b1;
            dbg_dat_n = TIMEOUT_DATA;
          end else begin
            wbs_ack_n = 1'b1;
            wbs_dat_n = TIMEOUT_DATA;
          end
        end else begin
          cnt_n = cnt_inc;
`endif
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.reg_cyc_o = stb_q;
  assign bus.reg_stb_o = stb_q;
  assign bus.reg_we_o  = req_q.we;
  assign bus.reg_sel_o = req_q.sel;
  assign bus.reg_adr_o = req_q.adr;
  assign bus.reg_dat_o = req_q.dat;
  assign bus.wbs_ack_o = wbs_ack_q;
  assign bus.wbs_dat_o = wbs_dat_q;
  assign bus.dbg_ack_o = dbg_ack_q;
  assign bus.dbg_dat_o = dbg_dat_q;
  assign err_o         = err_q;
endmodule

// File: doc/rapcores_bus_arbiter.md
# rapcores_bus_arbiter

Two-master arbiter that shares the RAPcores internal register bus between the management SoC Wishbone slave port and a logic-analyzer-driven debug master. It sits between the user-project wrapper pins and the RAPcores register file. It serialises accesses with round-robin fairness, registers all responses, and optionally terminates hung accesses with an error response.

## Interface
Parameters:
- ADR_W, 32: address width on all three buses.
- TIMEOUT_CYCLES, 255: cycles of `reg_stb_o` without `reg_ack_i` before forced termination. Range 1–255; 8-bit counter.

Ports:
- wb_clk_i  in  1  single clock for the block.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  M0 Wishbone classic request.
- wbs_sel_i  in  4  M0 byte selects.
- wbs_adr_i  in  ADR_W  M0 address.
- wbs_dat_i  in  32  M0 write data.
- wbs_ack_o  out  1  M0 acknowledge, one-cycle pulse.
- wbs_dat_o  out  32  M0 read data, valid with `wbs_ack_o`.
- dbg_req_i, dbg_we_i  in  1 each  M1 (LA debug) request level and write enable.
- dbg_sel_i  in  4  M1 byte selects.
- dbg_adr_i  in  ADR_W  M1 address.
- dbg_dat_i  in  32  M1 write data.
- dbg_ack_o  out  1  M1 acknowledge pulse.
- dbg_dat_o  out  32  M1 read data.
- reg_cyc_o, reg_stb_o, reg_we_o  out  1 each  shared register-bus request.
- reg_sel_o  out  4  shared bus byte selects.
- reg_adr_o  out  ADR_W  shared bus address.
- reg_dat_o  out  32  shared bus write data.
- reg_ack_i  in  1  register-file acknowledge.
- reg_dat_i  in  32  register-file read data.
- err_o  out  1  sticky timeout flag.

## Operation
- M0 requests when `wbs_cyc_i & wbs_stb_i`. M1 requests when `dbg_req_i`. Both masters hold the request and its qualifiers until they see their ack.
- State machine:
  - IDLE: with no request, stay in IDLE. With one request, grant that master. With both requesting, grant the master not recorded in `last_grant`. On grant, latch the master's adr/dat/sel/we into the output registers, update `last_grant`, and go to BUSY.
  - BUSY: `reg_cyc_o`/`reg_stb_o` stay high. On `reg_ack_i`, capture `reg_dat_i` into the granted master's `*_dat_o`, pulse that master's ack, and go to DONE.
  - BUSY, abort: if the granted master drops its request (`wbs_cyc_i` low, or `dbg_req_i` low) before `reg_ack_i`, drop `reg_cyc_o`/`reg_stb_o` and go to IDLE with no ack. If the drop and `reg_ack_i` arrive in the same cycle, the ack wins.
  - DONE: one cycle with no bus activity, so the master can deassert its request. Then go to IDLE.
- `last_grant` resets to M1, so M0 wins the first contention.
- The `*_dat_o` outputs hold their last value between acks.
- Only the granted master ever receives an ack.

## Timing
- Reset values: all request outputs and both acks 0; `reg_adr_o`/`reg_dat_o`/`reg_sel_o`/`*_dat_o` 0; `err_o` 0; state IDLE.
- Request sampled in IDLE at cycle N: `reg_stb_o` is high at N+1.
- `reg_ack_i` sampled at cycle M: master ack high for exactly cycle M+1, `reg_stb_o` low at M+1. The next grant can be sampled no earlier than M+2, so the next `reg_stb_o` appears at M+3 at the earliest.
- Minimum round trip with a zero-wait register file: 3 cycles from request to ack, 4 cycles per back-to-back access.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronous). No ack is issued. After release the block is in IDLE.

## Configuration
- `RAPCORES_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without `reg_ack_i`.
  - When the count reaches TIMEOUT_CYCLES, the block drops `reg_stb_o`, acks the granted master with data 32'hDEAD_BEEF, sets `err_o` (sticky until reset), and goes to DONE.
  - `reg_ack_i` in the same cycle as expiry takes priority and completes normally.
- Undefined: no counter. BUSY waits indefinitely. `err_o` is tied 0.

## Test plan
- M0 read of 0x3000_0004, register file acks one cycle after stb with 0x1234_5678 -> `wbs_ack_o` is a single pulse 3 cycles after request, `wbs_dat_o`=0x1234_5678, `dbg_ack_o` stays 0.
- M0 and M1 request in the same cycle, both held through 4 accesses -> grant order M0, M1, M0, M1, and `reg_adr_o` matches each master's address in turn.
- M1 write 0xA5A5_A5A5 with sel 4'b0011 -> `reg_we_o`=1, `reg_sel_o`=0011, `reg_dat_o`=0xA5A5_A5A5 held until ack. Only `dbg_ack_o` pulses.
- M0 drops `wbs_cyc_i` two cycles into BUSY with no `reg_ack_i` -> `reg_stb_o` low next cycle, no ack, the next request is granted normally.
- With `RAPCORES_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, register file never acks -> ack with 0xDEAD_BEEF after 16 BUSY cycles and `err_o`=1 until reset. Without the macro, no ack and `err_o`=0.
- Assert `wb_rst_ni` low during BUSY -> `reg_stb_o`, acks, and `err_o` go to 0 asynchronously. After release, a fresh M0 request completes.
